// File: rtl/pp_buf_pkg.sv
// Shared definitions for the ping-pong buffer: bank lifecycle encodings and skid sizing.
package pp_buf_pkg;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    // Words that may sit in the skid buffer plus the RAM read pipeline at once.
    function automatic int unsigned skid_limit();
        return 2;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// One ping-pong bank: inferred simple-dual-port RAM, synchronous write, registered 1-cycle read.
module pp_bank_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_pingpong_buf.sv
// Ping-pong buffer: the writer fills one RAM bank while the reader drains the other.
// Define PP_PARTIAL_FLUSH_EN to add wr_flush, which closes a partially filled bank early.
module ram_pingpong_buf
    import pp_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
`ifdef PP_PARTIAL_FLUSH_EN
    input  logic              wr_flush,
`endif
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic [1:0]        bank_full,
    output logic              wr_bank
);

    // Both streams: a word moves on a rising edge where valid && ready; once raised,
    // rd_valid holds (with rd_data/rd_last frozen) until the consumer takes the word.
    logic [1:0]        st_q [2];
    logic [1:0]        st_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              init_q;
    logic              infl_q, infl_last_q, infl_bank_q;
    logic [DATA_W-1:0] skid_data_q [2];
    logic [DATA_W-1:0] skid_data_d [2];
    logic              skid_last_q [2];
    logic              skid_last_d [2];
    logic [1:0]        skid_cnt_q, skid_cnt_d;

    logic              wr_fire, wr_wrap, wr_close;
    logic              rd_avail, rd_pop, rd_issue, rd_is_last;
    logic [2:0]        occ_after;
    logic [ADDR_W-1:0] rd_last_addr;
    logic [DATA_W-1:0] ram_rdata [2];
    logic [DATA_W-1:0] push_data;

    assign wr_ready = init_q && !st_q[wr_bank_q][1];
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_wrap  = wr_fire && (wr_addr_q == ADDR_W'(DEPTH - 1));

`ifdef PP_PARTIAL_FLUSH_EN
    logic [ADDR_W:0] len_q [2];
    logic [ADDR_W:0] len_d [2];
    assign wr_close     = wr_wrap || (wr_flush && (st_q[wr_bank_q] == ST_FILLING));
    assign rd_last_addr = ADDR_W'(len_q[rd_bank_q] - (ADDR_W+1)'(1));
`else
    assign wr_close     = wr_wrap;
    assign rd_last_addr = ADDR_W'(DEPTH - 1);
`endif

    // Issue only when the word can land in the skid buffer, counting this cycle's pop.
    assign rd_valid   = (skid_cnt_q != 2'd0);
    assign rd_pop     = rd_valid && rd_ready;
    assign rd_avail   = st_q[rd_bank_q][1];
    assign occ_after  = {1'b0, skid_cnt_q} + {2'b00, infl_q} - {2'b00, rd_pop};
    assign rd_issue   = rd_avail && (occ_after < 3'(skid_limit()));
    assign rd_is_last = (rd_addr_q == rd_last_addr);

    assign wr_addr_d  = wr_close ? '0 : (wr_fire ? wr_addr_q + ADDR_W'(1) : wr_addr_q);
    assign wr_bank_d  = wr_close ? !wr_bank_q : wr_bank_q;
    assign rd_addr_d  = rd_issue ? (rd_is_last ? '0 : rd_addr_q + ADDR_W'(1)) : rd_addr_q;
    assign rd_bank_d  = (rd_issue && rd_is_last) ? !rd_bank_q : rd_bank_q;

    // Writer and reader never act on the same bank, so the two updates cannot collide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
            if (wr_bank_q == 1'(b)) begin
                if (wr_close)     st_d[b] = ST_FULL;
                else if (wr_fire) st_d[b] = ST_FILLING;
            end
            if (rd_issue && (rd_bank_q == 1'(b)))
                st_d[b] = rd_is_last ? ST_EMPTY : ST_DRAINING;
`ifdef PP_PARTIAL_FLUSH_EN
            len_d[b] = len_q[b];
            if (wr_close && (wr_bank_q == 1'(b)))
                len_d[b] = {1'b0, wr_addr_q} + (wr_fire ? (ADDR_W+1)'(1) : '0);
`endif
        end
    end

    assign push_data = ram_rdata[infl_bank_q];

    always_comb begin
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_cnt_d  = skid_cnt_q;
        case ({infl_q, rd_pop})
            2'b10: begin
                skid_data_d[skid_cnt_q[0]] = push_data;
                skid_last_d[skid_cnt_q[0]] = infl_last_q;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid_data_d[0] = skid_data_q[1];
                skid_last_d[0] = skid_last_q[1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_data_d[0] = push_data;
                    skid_last_d[0] = infl_last_q;
                end else begin
                    skid_data_d[0] = skid_data_q[1];
                    skid_last_d[0] = skid_last_q[1];
                    skid_data_d[1] = push_data;
                    skid_last_d[1] = infl_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]        <= ST_EMPTY;
            st_q[1]        <= ST_EMPTY;
            wr_bank_q      <= 1'b0;
            wr_addr_q      <= '0;
            rd_bank_q      <= 1'b0;
            rd_addr_q      <= '0;
            init_q         <= 1'b0;
            infl_q         <= 1'b0;
            infl_last_q    <= 1'b0;
            infl_bank_q    <= 1'b0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_last_q[0] <= 1'b0;
            skid_last_q[1] <= 1'b0;
            skid_cnt_q     <= 2'd0;
`ifdef PP_PARTIAL_FLUSH_EN
            len_q[0]       <= '0;
            len_q[1]       <= '0;
`endif
        end else begin
            st_q           <= st_d;
            wr_bank_q      <= wr_bank_d;
            wr_addr_q      <= wr_addr_d;
            rd_bank_q      <= rd_bank_d;
            rd_addr_q      <= rd_addr_d;
            init_q         <= 1'b1;
            infl_q         <= rd_issue;
            infl_last_q    <= rd_is_last;
            infl_bank_q    <= rd_bank_q;
            skid_data_q    <= skid_data_d;
            skid_last_q    <= skid_last_d;
            skid_cnt_q     <= skid_cnt_d;
`ifdef PP_PARTIAL_FLUSH_EN
            len_q          <= len_d;
`endif
        end
    end

    pp_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram0 (
        .clk     (clk),
        .we_i    (wr_fire && !wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data),
        .re_i    (rd_issue && !rd_bank_q),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata[0])
    );

    pp_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram1 (
        .clk     (clk),
        .we_i    (wr_fire && wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data),
        .re_i    (rd_issue && rd_bank_q),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata[1])
    );

    assign rd_data   = skid_data_q[0];
    assign rd_last   = skid_last_q[0];
    assign bank_full = {st_q[1][1], st_q[0][1]};
    assign wr_bank   = wr_bank_q;

endmodule

// File: tb/tb_ram_pingpong_buf.sv
// Bench for ram_pingpong_buf: DEPTH=256 and DEPTH=4 instances share stimulus, sel picks the one checked.
// Define PP_PARTIAL_FLUSH_EN to also exercise the wr_flush sequence.
`timescale 1ns/1ps
module tb_ram_pingpong_buf;

    logic       clk = 1'b0;
    logic       rst_n, wr_valid, wr_flush, rd_ready, sel;
    logic [7:0] wr_data;

    logic       wr_ready_a, rd_valid_a, rd_last_a, wr_bank_a;
    logic [7:0] rd_data_a;
    logic [1:0] bank_full_a;
    logic       wr_ready_b, rd_valid_b, rd_last_b, wr_bank_b;
    logic [7:0] rd_data_b;
    logic [1:0] bank_full_b;

    logic       m_wr_ready, m_rd_valid, m_rd_last, m_wr_bank;
    logic [7:0] m_rd_data;
    logic [1:0] m_bank_full;

    always #5 clk = ~clk;

    ram_pingpong_buf #(.DATA_W(8), .DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef PP_PARTIAL_FLUSH_EN
        .wr_flush(wr_flush),
`endif
        .wr_ready(wr_ready_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_last(rd_last_a),
        .rd_ready(rd_ready), .bank_full(bank_full_a), .wr_bank(wr_bank_a)
    );

    ram_pingpong_buf #(.DATA_W(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef PP_PARTIAL_FLUSH_EN
        .wr_flush(wr_flush),
`endif
        .wr_ready(wr_ready_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
        .rd_ready(rd_ready), .bank_full(bank_full_b), .wr_bank(wr_bank_b)
    );

    assign m_wr_ready  = sel ? wr_ready_b  : wr_ready_a;
    assign m_rd_valid  = sel ? rd_valid_b  : rd_valid_a;
    assign m_rd_data   = sel ? rd_data_b   : rd_data_a;
    assign m_rd_last   = sel ? rd_last_b   : rd_last_a;
    assign m_bank_full = sel ? bank_full_b : bank_full_a;
    assign m_wr_bank   = sel ? wr_bank_b   : wr_bank_a;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_read, n_last;
    logic [8:0] exp_q [$];
    logic       hold_v;
    logic [8:0] hold_w;

    typedef struct {
        logic       sel;
        int         n_words;
        int         rd_mode;      // 0: always ready, 1: hold off until writer stalls, 2: toggle
        int         base;
        int         exp_last;
        int         exp_stall_at; // -1 never stalls, -2 don't care
        logic [1:0] exp_full;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive at the falling edge, book the transfers the next rising edge will make.
    task automatic tick(input logic wv, input logic [7:0] wd, input logic wl, input logic fl,
                        input logic rr, input int ewb, output logic wfire);
        logic [8:0] exp_w;
        @(negedge clk);
        if (hold_v) begin
            check("hold_valid", 32'(m_rd_valid), 32'd1);
            check("hold_word", 32'({m_rd_last, m_rd_data}), 32'(hold_w));
        end
        wr_valid = wv;
        wr_data  = wd;
        wr_flush = fl;
        rd_ready = rr;
        wfire = wv && m_wr_ready;
        if (wfire) begin
            if (ewb >= 0) check("wr_bank", 32'(m_wr_bank), 32'(ewb));
            exp_q.push_back({wl, wd});
        end
        if (m_rd_valid && rr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_extra: got word %0h expected none", {m_rd_last, m_rd_data});
            end else begin
                exp_w = exp_q.pop_front();
                check("rd_word", 32'({m_rd_last, m_rd_data}), 32'(exp_w));
            end
            n_read++;
            if (m_rd_last) n_last++;
        end
        hold_v = m_rd_valid && !rr;
        hold_w = {m_rd_last, m_rd_data};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_flush = 1'b0; rd_ready = 1'b0;
        exp_q.delete();
        hold_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_case(input int n_words, input int rd_mode, input int base, input int abort_at,
                            output int stall_at, output logic [1:0] full_at_stall);
        int   written, cyc, stall_cyc, depth;
        logic wv, rr, wf;
        depth = sel ? 4 : 256;
        written = 0; cyc = 0; stall_cyc = 0;
        stall_at = -1; full_at_stall = 2'b00;
        n_read = 0; n_last = 0;
        while (!(written >= n_words && exp_q.size() == 0) &&
               !(abort_at > 0 && n_read >= abort_at) && cyc < 20000) begin
            wv = (written < n_words);
            case (rd_mode)
                0:       rr = 1'b1;
                1:       rr = (stall_cyc >= 5);
                default: rr = ((cyc % 2) == 0);
            endcase
            tick(wv, 8'(base + written), (written % depth) == depth - 1, 1'b0, rr,
                 (written / depth) % 2, wf);
            if (wf) written++;
            else if (wv) begin
                if (stall_at < 0) begin
                    stall_at = written;
                    full_at_stall = m_bank_full;
                end
                stall_cyc++;
            end
            cyc++;
        end
        if (cyc >= 20000) begin
            n_checks++;
            $display("FAIL timeout: %0d of %0d words read", n_read, n_words);
        end
    endtask

    task automatic settle();
        logic wf;
        repeat (4) tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, -1, wf);
        check("idle_rd_valid", 32'(m_rd_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         st_at, cyc;
        logic [1:0] fl_at;
        logic       wf;

        rst_n = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_flush = 1'b0;
        rd_ready = 1'b0; sel = 1'b0; hold_v = 1'b0; hold_w = '0;

        vecs[0] = '{1'b0, 512, 0, 0,   2, -1,  2'b00};
        // 768 rather than 600 words: only whole banks drain without a flush
        vecs[1] = '{1'b0, 768, 1, 0,   3, 512, 2'b11};
        vecs[2] = '{1'b0, 512, 2, 7,   2, -2,  2'b00};
        vecs[3] = '{1'b1, 16,  0, 100, 4, -1,  2'b00};

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wr_ready",  32'(m_wr_ready),  32'd0);
        check("rst_rd_valid",  32'(m_rd_valid),  32'd0);
        check("rst_rd_last",   32'(m_rd_last),   32'd0);
        check("rst_rd_data",   32'(m_rd_data),   32'd0);
        check("rst_bank_full", 32'(m_bank_full), 32'd0);
        check("rst_wr_bank",   32'(m_wr_bank),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_rst", 32'(m_wr_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            sel = vecs[i].sel;
            do_reset();
            run_case(vecs[i].n_words, vecs[i].rd_mode, vecs[i].base, 0, st_at, fl_at);
            settle();
            check("n_read", 32'(n_read), 32'(vecs[i].n_words));
            check("n_last", 32'(n_last), 32'(vecs[i].exp_last));
            if (vecs[i].exp_stall_at != -2) check("stall_at", 32'(st_at), 32'(vecs[i].exp_stall_at));
            if (vecs[i].exp_stall_at >= 0) check("full_at_stall", 32'(fl_at), 32'(vecs[i].exp_full));
        end

        // Reset in the middle of draining, then only fresh data may appear.
        sel = 1'b0;
        do_reset();
        run_case(256, 0, 0, 100, st_at, fl_at);
        check("pre_rst_valid", 32'(m_rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_valid",  32'(m_rd_valid),  32'd0);
        check("mid_rst_bank_full", 32'(m_bank_full), 32'd0);
        exp_q.delete();
        hold_v = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(256, 0, 1000, 0, st_at, fl_at);
        settle();
        check("post_rst_n_read", 32'(n_read), 32'd256);
        check("post_rst_n_last", 32'(n_last), 32'd1);

`ifdef PP_PARTIAL_FLUSH_EN
        sel = 1'b0;
        do_reset();
        n_read = 0; n_last = 0;
        tick(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, -1, wf);
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, -1, wf);
        check("flush_empty_full", 32'(m_bank_full), 32'd0);
        check("flush_empty_bank", 32'(m_wr_bank), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'(50 + i), i == 9, 1'b0, 1'b1, 0, wf);
            check("flush_wr_fire", 32'(wf), 32'd1);
        end
        tick(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, -1, wf);
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, -1, wf);
        check("flush_bank_swap", 32'(m_wr_bank), 32'd1);
        check("flush_full0", 32'(m_bank_full[0]), 32'd1);
        // Second bank closes with a flush that coincides with its 4th write.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'(80 + i), i == 3, i == 3, 1'b1, 1, wf);
            check("flush_wr_fire2", 32'(wf), 32'd1);
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, -1, wf);
            cyc++;
        end
        settle();
        check("flush_n_read", 32'(n_read), 32'd14);
        check("flush_n_last", 32'(n_last), 32'd2);
        check("flush_wr_bank_end", 32'(m_wr_bank), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
